// File: rtl/store_pkg.sv
// Shared types and helpers for the store alignment path.
// Optional build macro: STORE_MISALIGNED_SPLIT_EN (see store_align_unit).
package store_pkg;

   localparam logic [6:0] OPC_STORE = 7'b0100011;

   typedef enum logic [1:0] {
      SZ_B = 2'd0,
      SZ_H = 2'd1,
      SZ_W = 2'd2,
      SZ_D = 2'd3
   } size_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BEAT0 = 2'd1,
      BEAT1 = 2'd2
   } state_e;

   function automatic logic [3:0] bytes_of(size_e sz);
      return 4'd1 << sz;
   endfunction

endpackage

// File: rtl/store_lane_shift.sv
// Combinational store formatter: masks data to the access size and
// shifts data/strobes into a double-width lane window.
module store_lane_shift
   import store_pkg::*;
#(
   parameter  int XLEN   = 32,
   localparam int STRB_W = XLEN / 8,
   localparam int OFF_W  = $clog2(STRB_W)
) (
   input  logic [1:0]          i_size,
   input  logic [OFF_W-1:0]    i_off,
   input  logic [XLEN-1:0]     i_data,
   output logic [2*XLEN-1:0]   o_data,
   output logic [2*STRB_W-1:0] o_strb
);

   logic [STRB_W-1:0] w_strb;
   logic [XLEN-1:0]   w_mask;

   // enable the low lanes covered by the access size
   always_comb begin
      w_strb = '0;
      w_mask = '0;
      for (int b = 0; b < STRB_W; b++) begin
         if (b < int'(bytes_of(size_e'(i_size)))) begin
            w_strb[b]       = 1'b1;
            w_mask[8*b +: 8] = 8'hFF;
         end
      end
   end

   assign o_data = {{XLEN{1'b0}}, i_data & w_mask} << {i_off, 3'b000};
   assign o_strb = {{STRB_W{1'b0}}, w_strb} << i_off;

endmodule

// File: rtl/store_align_unit.sv
// Store request to lane-aligned memory write beat with byte strobes.
// Macro STORE_MISALIGNED_SPLIT_EN enables misaligned and word-crossing stores.
module store_align_unit
   import store_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int ADDR_W = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [6:0]          req_opcode,
   input  logic [2:0]          req_funct3,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [XLEN-1:0]     req_data,
   output logic                mem_valid,
   input  logic                mem_ready,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [XLEN-1:0]     mem_wdata,
   output logic [XLEN/8-1:0]   mem_wstrb,
   output logic                mem_last,
   output logic                store_err
);

   localparam int STRB_W = XLEN / 8;
   localparam int OFF_W  = $clog2(STRB_W);

   state_e              r_state;
   state_e              w_next;
   logic [ADDR_W-1:0]   r_addr;
   logic [XLEN-1:0]     r_wdata;
   logic [STRB_W-1:0]   r_wstrb;
   logic                r_last;
   logic                r_err;

   logic                w_accept;
   logic                w_store;
   logic                w_f3_bad;
   logic                w_err;
   logic                w_split;
   logic                w_load;
   logic [OFF_W-1:0]    w_off;
   logic [2*XLEN-1:0]   w_sh_data;
   logic [2*STRB_W-1:0] w_sh_strb;

   store_lane_shift #(.XLEN(XLEN)) u_shift (
      .i_size (req_funct3[1:0]),
      .i_off  (w_off),
      .i_data (req_data),
      .o_data (w_sh_data),
      .o_strb (w_sh_strb)
   );

   assign w_off    = req_addr[OFF_W-1:0];
   assign w_store  = (req_opcode == OPC_STORE);
   assign w_f3_bad = req_funct3[2] |
                     ((XLEN == 32) & (req_funct3[1:0] == 2'b11));

`ifdef STORE_MISALIGNED_SPLIT_EN
   logic                w_adv;
   logic [XLEN-1:0]     r_hi_data;
   logic [STRB_W-1:0]   r_hi_strb;

   assign w_err   = w_f3_bad;
   assign w_split = |w_sh_strb[2*STRB_W-1:STRB_W];
`else
   logic [OFF_W-1:0]    w_amask;
   logic                w_misal;
   logic                w_unused;

   assign w_amask  = OFF_W'(bytes_of(size_e'(req_funct3[1:0])) - 4'd1);
   assign w_misal  = |(w_off & w_amask);
   assign w_err    = w_f3_bad | w_misal;
   assign w_split  = 1'b0;
   assign w_unused = ^{w_sh_data[2*XLEN-1:XLEN],
                       w_sh_strb[2*STRB_W-1:STRB_W]};
`endif

   assign mem_valid = (r_state != IDLE);
   assign mem_addr  = r_addr;
   assign mem_wdata = r_wdata;
   assign mem_wstrb = r_wstrb;
   assign mem_last  = r_last;
   assign store_err = r_err;
   assign req_ready = !mem_valid | (mem_ready & r_last);
   assign w_accept  = req_valid & req_ready;

   // next state: load a new store, advance to the high beat, or drain
   always_comb begin
      w_next = r_state;
      w_load = 1'b0;
`ifdef STORE_MISALIGNED_SPLIT_EN
      w_adv  = 1'b0;
`endif
      if (w_accept & w_store & ~w_err) begin
         w_next = BEAT0;
         w_load = 1'b1;
      end else if (mem_valid & mem_ready) begin
         w_next = IDLE;
`ifdef STORE_MISALIGNED_SPLIT_EN
         if ((r_state == BEAT0) && !r_last) begin
            w_next = BEAT1;
            w_adv  = 1'b1;
         end
`endif
      end
   end

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   // beat registers and error pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_addr  <= '0;
         r_wdata <= '0;
         r_wstrb <= '0;
         r_last  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_err <= w_accept & w_store & w_err;
         if (w_load) begin
            r_addr  <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            r_wdata <= w_sh_data[XLEN-1:0];
            r_wstrb <= w_sh_strb[STRB_W-1:0];
            r_last  <= ~w_split;
`ifdef STORE_MISALIGNED_SPLIT_EN
         end else if (w_adv) begin
            r_addr  <= r_addr + ADDR_W'(STRB_W);
            r_wdata <= r_hi_data;
            r_wstrb <= r_hi_strb;
            r_last  <= 1'b1;
`endif
         end else if (w_next == IDLE) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_wstrb <= '0;
            r_last  <= 1'b0;
         end
      end
   end

`ifdef STORE_MISALIGNED_SPLIT_EN
   // high half of a word-crossing store, held until beat1
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hi_data <= '0;
         r_hi_strb <= '0;
      end else if (w_load) begin
         r_hi_data <= w_sh_data[2*XLEN-1:XLEN];
         r_hi_strb <= w_sh_strb[2*STRB_W-1:STRB_W];
      end
   end
`endif

endmodule

// File: tb/tb_store_align_unit.sv
// Randomized self-checking bench for store_align_unit (XLEN=32).
// Model follows STORE_MISALIGNED_SPLIT_EN if defined for the build.
module tb_store_align_unit;
   import store_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [6:0]  req_opcode;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_data;
   logic        mem_valid;
   logic        mem_ready;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_last;
   logic        store_err;

   store_align_unit #(.XLEN(32), .ADDR_W(32)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_opcode (req_opcode),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_data   (req_data),
      .mem_valid  (mem_valid),
      .mem_ready  (mem_ready),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_wstrb  (mem_wstrb),
      .mem_last   (mem_last),
      .store_err  (store_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  s;
      logic        l;
   } beat_t;

   beat_t q[$];
   int    n_cmp = 0;
   int    n_bad = 0;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // rejected when size illegal or (without split support) misaligned
   function automatic bit bad_req(input logic [2:0] f3,
                                  input logic [31:0] a);
      int n;
      n = 1 << f3[1:0];
      if (f3 > 3'd2) return 1'b1;
`ifndef STORE_MISALIGNED_SPLIT_EN
      if ((int'(a[1:0]) % n) != 0) return 1'b1;
`endif
      return 1'b0;
   endfunction

   // place each stored byte at its memory word/lane
   task automatic push_beats(input logic [31:0] a, input logic [2:0] f3,
                             input logic [31:0] d);
      int    n, off, nb, pos, k, lane;
      beat_t b[2];
      n   = 1 << f3[1:0];
      off = int'(a[1:0]);
      nb  = (off + n > 4) ? 2 : 1;
      for (int j = 0; j < 2; j++) begin
         b[j].a = (a & 32'hFFFF_FFFC) + 32'(4 * j);
         b[j].d = '0;
         b[j].s = '0;
         b[j].l = (j == nb - 1);
      end
      for (int i = 0; i < n; i++) begin
         pos  = off + i;
         k    = pos / 4;
         lane = pos % 4;
         b[k].d = b[k].d | (((d >> (8 * i)) & 32'hFF) << (8 * lane));
         b[k].s = b[k].s | 4'(1 << lane);
      end
      for (int j = 0; j < nb; j++) q.push_back(b[j]);
   endtask

   localparam int ND = 9;
   logic [6:0]  d_op [ND] = '{OPC_STORE, OPC_STORE, OPC_STORE, OPC_STORE,
                              7'b0000011, OPC_STORE, OPC_STORE, OPC_STORE,
                              OPC_STORE};
   logic [2:0]  d_f3 [ND] = '{3'd2, 3'd0, 3'd1, 3'd4, 3'd2, 3'd1, 3'd1,
                              3'd2, 3'd3};
   logic [31:0] d_a  [ND] = '{32'h100, 32'h103, 32'h103, 32'h100, 32'h200,
                              32'hFFFF_FFFF, 32'h102, 32'h101, 32'h108};
   logic [31:0] d_d  [ND] = '{32'hDEADBEEF, 32'h123456AB, 32'h0000BEEF,
                              32'h11111111, 32'h22222222, 32'h0000A55A,
                              32'h00001234, 32'hCAFEF00D, 32'h33333333};

   bit exp_err;
   bit exp_ready;
   bit acc;
   int di;

   initial begin
      rst_n      = 1'b0;
      req_valid  = 1'b0;
      req_opcode = '0;
      req_funct3 = '0;
      req_addr   = '0;
      req_data   = '0;
      mem_ready  = 1'b0;
      exp_err    = 1'b0;
      acc        = 1'b0;
      di         = 0;
      repeat (2) @(negedge clk);
      chk("rst_valid", mem_valid, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_wdata", mem_wdata, 0);
      chk("rst_wstrb", mem_wstrb, 0);
      chk("rst_last", mem_last, 0);
      chk("rst_err", store_err, 0);
      chk("rst_ready", req_ready, 1);
      rst_n = 1'b1;

      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk);
         if (!req_valid || acc) begin
            if (di < ND) begin
               req_valid  = 1'b1;
               req_opcode = d_op[di];
               req_funct3 = d_f3[di];
               req_addr   = d_a[di];
               req_data   = d_d[di];
               di++;
            end else begin
               req_valid  = ($urandom_range(0, 3) != 0);
               req_opcode = ($urandom_range(0, 9) == 0) ? 7'b0000011
                                                        : OPC_STORE;
               req_funct3 = ($urandom_range(0, 9) < 8)
                            ? 3'($urandom_range(0, 2))
                            : 3'($urandom_range(3, 7));
               req_addr   = ($urandom_range(0, 15) == 0)
                            ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3))
                            : $urandom;
               req_data   = $urandom;
            end
         end
         mem_ready = ($urandom_range(0, 3) != 0);
         #1;
         exp_ready = (q.size() == 0) || (q.size() == 1 && mem_ready);
         chk("req_ready", req_ready, exp_ready);
         chk("mem_valid", mem_valid, q.size() != 0);
         chk("store_err", store_err, exp_err);
         if (q.size() != 0) begin
            chk("mem_addr", mem_addr, q[0].a);
            chk("mem_wdata", mem_wdata, q[0].d);
            chk("mem_wstrb", mem_wstrb, q[0].s);
            chk("mem_last", mem_last, q[0].l);
            if (mem_ready) void'(q.pop_front());
         end
         exp_err = 1'b0;
         acc = req_valid && exp_ready;
         if (acc && req_opcode == OPC_STORE) begin
            if (bad_req(req_funct3, req_addr)) exp_err = 1'b1;
            else push_beats(req_addr, req_funct3, req_data);
         end
      end

      // drain, then reset in the middle of an outstanding store
      @(negedge clk);
      req_valid = 1'b0;
      mem_ready = 1'b1;
      repeat (3) @(negedge clk);
      q.delete();
      req_valid  = 1'b1;
      req_opcode = OPC_STORE;
`ifdef STORE_MISALIGNED_SPLIT_EN
      req_funct3 = 3'd1;
      req_addr   = 32'h103;
      req_data   = 32'h0000BEEF;
`else
      req_funct3 = 3'd2;
      req_addr   = 32'h100;
      req_data   = 32'hDEADBEEF;
`endif
      mem_ready = 1'b0;
      @(negedge clk);
      req_valid = 1'b0;
      chk("mid_valid", mem_valid, 1);
`ifdef STORE_MISALIGNED_SPLIT_EN
      mem_ready = 1'b1;
      @(negedge clk);
      mem_ready = 1'b0;
      chk("mid_b1_addr", mem_addr, 32'h104);
      chk("mid_b1_last", mem_last, 1);
`endif
      #2 rst_n = 1'b0;
      #1;
      chk("ar_valid", mem_valid, 0);
      chk("ar_addr", mem_addr, 0);
      chk("ar_wdata", mem_wdata, 0);
      chk("ar_wstrb", mem_wstrb, 0);
      chk("ar_last", mem_last, 0);
      chk("ar_err", store_err, 0);
      @(negedge clk);
      rst_n     = 1'b1;
      mem_ready = 1'b1;
      repeat (3) begin
         @(negedge clk);
         #1;
         chk("post_valid", mem_valid, 0);
         chk("post_ready", req_ready, 1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/store_align_unit.md
Name: store_align_unit

Overview:
- Parametrised successor to the store-data formatter in the RISC-V memory stage.
- Takes a store request (opcode, funct3, address, register data) and produces a lane-aligned memory write beat with byte strobes.
- Handshakes on both sides and zero-fills unused lanes.
- Supports SB/SH/SW, and SD when XLEN=64.
- Optionally splits word-crossing misaligned stores into two beats.

Parameters:
- XLEN, 32, data path width in bits (32 or 64); STRB_W = XLEN/8, OFF_W = log2(STRB_W).
- ADDR_W, 32, byte address width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  store request valid.
- req_ready  out  1  request accepted when valid & ready.
- req_opcode  in  7  instruction opcode; only 7'b0100011 is a store.
- req_funct3  in  3  store size: 000 byte, 001 half, 010 word, 011 double.
- req_addr  in  ADDR_W  byte address.
- req_data  in  XLEN  rs2 data, LSB-justified.
- mem_valid  out  1  write beat valid.
- mem_ready  in  1  memory accepts beat.
- mem_addr  out  ADDR_W  word-aligned address (low OFF_W bits = 0).
- mem_wdata  out  XLEN  lane-shifted data; non-strobed lanes = 0.
- mem_wstrb  out  STRB_W  byte enables.
- mem_last  out  1  final beat of the store.
- store_err  out  1  one-cycle pulse: illegal or misaligned store rejected.

Behaviour:
- Reset (async, rst_n=0): mem_valid=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, mem_last=0, store_err=0, state=IDLE. Any pending second beat is discarded.
- Ready rule: req_ready = !mem_valid | (mem_ready & mem_last), evaluated combinationally. This allows back-to-back single-beat stores at one store per cycle.
- Latency: a request accepted at edge N is presented on mem_* from cycle N+1.
- Size: bytes = 1 << funct3[1:0].
  - funct3[2]=1 is illegal.
  - funct3=011 is illegal when XLEN=32.
- Offset: off = req_addr[OFF_W-1:0].
  - Form a 2*XLEN value: data masked to size, shifted left by 8*off.
  - Form a 2*STRB_W strobe: ((1<<bytes)-1) << off.
  - The low half forms beat0; the high half forms beat1.
- Non-store opcode: request is consumed; no beat and no error are produced.
- Illegal funct3 on a store: request is consumed; store_err=1 for the next cycle; no beat.
- FSM states:
  - IDLE: no beat pending. On an accepted legal store, go to BEAT0.
  - BEAT0: mem_valid=1, beat0 presented.
    - Single beat: mem_last=1; on mem_ready, go to IDLE, or reload BEAT0 if a new request is accepted in the same cycle.
    - Split: mem_last=0; on mem_ready, go to BEAT1.
  - BEAT1: mem_addr = beat0 addr + STRB_W, high-half data and strobes, mem_last=1. On mem_ready, go to IDLE or reload BEAT0.
- Hold rule: mem_* must stay stable while mem_valid & !mem_ready.
- Address wrap: beat1 address wraps modulo 2^ADDR_W.
- store_err is never asserted in the same cycle as mem_valid for the same request.

Optional Feature:
- Macro STORE_MISALIGNED_SPLIT_EN.
- Defined:
  - Misaligned stores within one word go out as a single beat with shifted strobes (e.g. SH at off=1 gives wstrb 0110).
  - Word-crossing stores are split into BEAT0/BEAT1.
- Undefined:
  - Any store with off not a multiple of bytes is rejected: store_err pulse, no beat.
  - BEAT1 state and the high-half logic are removed.

Decomposition:
- Package store_pkg:
  - OPC_STORE = 7'b0100011.
  - Size enum (SZ_B/SZ_H/SZ_W/SZ_D).
  - State enum (IDLE/BEAT0/BEAT1).
  - Function bytes_of(size).
- Sub-module store_lane_shift: purely combinational data/strobe shifter producing the 2*XLEN data and 2*STRB_W strobe. The FSM and handshake stay in store_align_unit.

Test Plan:
- SW addr=0x100, data=0xDEADBEEF, mem_ready=1 -> one beat: addr 0x100, wdata 0xDEADBEEF, wstrb 1111, last=1, at N+1.
- SB addr=0x103, data=0x123456AB -> addr 0x100, wdata 0xAB000000, wstrb 1000, last=1.
- SH addr=0x103, data=0xBEEF:
  - With macro: beat0 addr 0x100, wdata 0xEF000000, wstrb 1000, last=0; beat1 addr 0x104, wdata 0x000000BE, wstrb 0001, last=1.
  - Without macro: store_err pulse, no mem_valid.
- Backpressure: mem_ready=0 for 3 cycles during SW -> mem_* stable, req_ready=0; release -> one beat, then req_ready=1.
- funct3=100 with store opcode -> store_err=1 for exactly one cycle, no beat. Opcode 0000011 -> silently consumed, no beat, no error.
- Reset mid-split (rst_n low while in BEAT1) -> all outputs 0 immediately; after release no beat1 is issued and req_ready=1.
